// File: rtl/rv_core_pkg.sv
// Shared core-wide constants and types for the integer datapath.
package rv_core_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_COUNT    = 32;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] xlen_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits used by decode to detect RAW hazards.
// Issue marks a destination busy, writeback clears it, and flush wipes everything.
module regfile_scoreboard
    import rv_core_pkg::*;
#(
    parameter int DEPTH    = REG_COUNT,
    parameter int AW       = $clog2(DEPTH),
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 issue_en_i,
    input  logic [AW-1:0]        issue_index_i,
    input  logic                 wr_en_i,
    input  logic [AW-1:0]        wr_index_i,
    input  logic                 flush_i,
    input  logic [NUM_RD*AW-1:0] rd_index_i,
    output logic [NUM_RD-1:0]    busy_o
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Next busy state: flush beats everything, and a same-cycle issue beats the clear.
    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en_i && (wr_index_i == AW'(i))) begin
                    busy_d[i] = 1'b0;
                end
                if (issue_en_i && (issue_index_i == AW'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
                    busy_d[i] = 1'b1;
                end
            end
        end
    end

    // Busy bit storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Per-port lookup; out-of-range indices never match, so they report not busy.
    always_comb begin
        busy_o = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_index_i[p*AW +: AW] == AW'(i)) begin
                    busy_o[p] = busy_q[i];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read, single-write integer register file with optional hardwired x0,
// write-to-read bypass, registered read and a busy scoreboard for decode.
module regfile_mp
    import rv_core_pkg::*;
#(
    parameter int XLEN         = XLEN_DEFAULT,
    parameter int DEPTH        = REG_COUNT,
    parameter int AW           = $clog2(DEPTH),
    parameter int NUM_RD       = 2,
    parameter int ZERO_REG     = 1,
    parameter int BYPASS       = 1,
    parameter int READ_LATENCY = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_en_i,
    input  logic [AW-1:0]          wr_index_i,
    input  logic [XLEN-1:0]        wr_data_i,
    input  logic [NUM_RD-1:0]      rd_en_i,
    input  logic [NUM_RD*AW-1:0]   rd_index_i,
    output logic [NUM_RD*XLEN-1:0] rd_data_o,
    output logic [NUM_RD-1:0]      rd_busy_o,
    input  logic                   issue_en_i,
    input  logic [AW-1:0]          issue_index_i,
    input  logic                   flush_i
);

    logic [XLEN-1:0]        regs_q [DEPTH];
    logic                   wrAccepted;
    logic [NUM_RD-1:0]      sbBusy;
    logic [NUM_RD*XLEN-1:0] rdData_d;
    logic [NUM_RD-1:0]      rdBusy_d;

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .issue_en_i    (issue_en_i),
        .issue_index_i (issue_index_i),
        .wr_en_i       (wr_en_i),
        .wr_index_i    (wr_index_i),
        .flush_i       (flush_i),
        .rd_index_i    (rd_index_i),
        .busy_o        (sbBusy)
    );

    // A write really lands only when the target exists and is not the hardwired zero.
    always_comb begin
        wrAccepted = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en_i && (wr_index_i == AW'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
                wrAccepted = 1'b1;
            end
        end
    end

    // Register storage; reset wins over a write in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en_i && (wr_index_i == AW'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
                    regs_q[i] <= wr_data_i;
                end
            end
        end
    end

    // Per-port read value and busy flag, including x0, bypass and enable masking.
    always_comb begin
        rdData_d = '0;
        rdBusy_d = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_index_i[p*AW +: AW] == AW'(i)) begin
                    rdData_d[p*XLEN +: XLEN] = regs_q[i];
                end
            end
            if ((ZERO_REG != 0) && (rd_index_i[p*AW +: AW] == '0)) begin
                rdData_d[p*XLEN +: XLEN] = '0;
            end
            if ((BYPASS != 0) && wrAccepted && (wr_index_i == rd_index_i[p*AW +: AW])) begin
                rdData_d[p*XLEN +: XLEN] = wr_data_i;
            end
            rdBusy_d[p] = sbBusy[p] & rd_en_i[p];
            if ((BYPASS != 0) && wr_en_i && (wr_index_i == rd_index_i[p*AW +: AW])) begin
                rdBusy_d[p] = 1'b0;
            end
            if (!rd_en_i[p]) begin
                rdData_d[p*XLEN +: XLEN] = '0;
            end
        end
    end

    if (READ_LATENCY == 0) begin : g_comb_read
        assign rd_data_o = rdData_d;
        assign rd_busy_o = rdBusy_d;
    end else begin : g_reg_read
        logic [NUM_RD*XLEN-1:0] rdData_q;
        logic [NUM_RD-1:0]      rdBusy_q;

        // Output pipeline stage keeping data and busy aligned.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rdData_q <= '0;
                rdBusy_q <= '0;
            end else begin
                rdData_q <= rdData_d;
                rdBusy_q <= rdBusy_d;
            end
        end

        assign rd_data_o = rdData_q;
        assign rd_busy_o = rdBusy_q;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp using three configurations sharing one stimulus:
// A = bypass, combinational read; B = no bypass, combinational; C = bypass, registered.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic        wrEn;
    logic [4:0]  wrIndex;
    logic [31:0] wrData;
    logic [1:0]  rdEn;
    logic [9:0]  rdIndex;
    logic        issueEn;
    logic [4:0]  issueIndex;
    logic        flush;

    logic [63:0] rdDataA, rdDataB, rdDataC;
    logic [1:0]  rdBusyA, rdBusyB, rdBusyC;

    int checks;
    int failures;

    regfile_mp #(.BYPASS(1), .READ_LATENCY(0)) dutA (
        .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wrEn), .wr_index_i(wrIndex), .wr_data_i(wrData),
        .rd_en_i(rdEn), .rd_index_i(rdIndex), .rd_data_o(rdDataA), .rd_busy_o(rdBusyA),
        .issue_en_i(issueEn), .issue_index_i(issueIndex), .flush_i(flush)
    );

    regfile_mp #(.BYPASS(0), .READ_LATENCY(0)) dutB (
        .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wrEn), .wr_index_i(wrIndex), .wr_data_i(wrData),
        .rd_en_i(rdEn), .rd_index_i(rdIndex), .rd_data_o(rdDataB), .rd_busy_o(rdBusyB),
        .issue_en_i(issueEn), .issue_index_i(issueIndex), .flush_i(flush)
    );

    regfile_mp #(.BYPASS(1), .READ_LATENCY(1)) dutC (
        .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wrEn), .wr_index_i(wrIndex), .wr_data_i(wrData),
        .rd_en_i(rdEn), .rd_index_i(rdIndex), .rd_data_o(rdDataC), .rd_busy_o(rdBusyC),
        .issue_en_i(issueEn), .issue_index_i(issueIndex), .flush_i(flush)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        wrEn       = 1'b0;
        wrIndex    = '0;
        wrData     = '0;
        rdEn       = '0;
        rdIndex    = '0;
        issueEn    = 1'b0;
        issueIndex = '0;
        flush      = 1'b0;
    endtask

    task automatic applyStimulus(input logic [1:0] en, input logic [4:0] idx1, input logic [4:0] idx0);
        rdEn    = en;
        rdIndex = {idx1, idx0};
    endtask

    task automatic doWrite(input logic [4:0] idx, input logic [31:0] data);
        wrEn    = 1'b1;
        wrIndex = idx;
        wrData  = data;
        tick();
        wrEn    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        setIdle();
        applyStimulus(2'b11, 5'd5, 5'd5);
        #7;
        checks++;
        if (rdDataC !== 64'h0) begin
            failures++;
            $display("[TB] FAIL reset_regout got=%h exp=%h", rdDataC, 64'h0);
        end
        #5;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(2'b11, 5'(i), 5'(i));
            tick();
            checks++;
            if ({rdDataA, rdBusyA} !== 66'h0) begin
                failures++;
                $display("[TB] FAIL reset_read_comb idx=%0d got=%h/%b exp=0/00", i, rdDataA, rdBusyA);
            end
            checks++;
            if ({rdDataC, rdBusyC} !== 66'h0) begin
                failures++;
                $display("[TB] FAIL reset_read_reg idx=%0d got=%h/%b exp=0/00", i, rdDataC, rdBusyC);
            end
        end
        doWrite(5'd5, 32'h0000_0011);
        applyStimulus(2'b01, 5'd0, 5'd5);
        #1;
        checks++;
        if (rdDataA[31:0] !== 32'h0000_0011) begin
            failures++;
            $display("[TB] FAIL pre_reset_x5 got=%h exp=%h", rdDataA[31:0], 32'h0000_0011);
        end
        wrEn    = 1'b1;
        wrIndex = 5'd5;
        wrData  = 32'hDEAD_BEEF;
        rst_n   = 1'b0;
        tick();
        rst_n = 1'b1;
        wrEn  = 1'b0;
        #1;
        checks++;
        if (rdDataA[31:0] !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_midwrite_x5 got=%h exp=%h", rdDataA[31:0], 32'h0);
        end
    endtask

    task automatic test_write_read();
        doWrite(5'd0, 32'hFFFF_FFFF);
        doWrite(5'd7, 32'h1234_5678);
        applyStimulus(2'b11, 5'd7, 5'd0);
        tick();
        checks++;
        if (rdDataA !== 64'h1234_5678_0000_0000) begin
            failures++;
            $display("[TB] FAIL wr_x0_x7_comb got=%h exp=%h", rdDataA, 64'h1234_5678_0000_0000);
        end
        checks++;
        if (rdDataC !== 64'h1234_5678_0000_0000) begin
            failures++;
            $display("[TB] FAIL wr_x0_x7_reg got=%h exp=%h", rdDataC, 64'h1234_5678_0000_0000);
        end
        applyStimulus(2'b01, 5'd7, 5'd0);
        #1;
        checks++;
        if (rdDataA[63:32] !== 32'h0) begin
            failures++;
            $display("[TB] FAIL rd_en_off_comb got=%h exp=%h", rdDataA[63:32], 32'h0);
        end
        tick();
        checks++;
        if (rdDataC[63:32] !== 32'h0) begin
            failures++;
            $display("[TB] FAIL rd_en_off_reg got=%h exp=%h", rdDataC[63:32], 32'h0);
        end
    endtask

    task automatic test_bypass();
        doWrite(5'd3, 32'h0000_000A);
        wrEn    = 1'b1;
        wrIndex = 5'd3;
        wrData  = 32'h0000_000B;
        applyStimulus(2'b01, 5'd0, 5'd3);
        #2;
        checks++;
        if (rdDataA[31:0] !== 32'h0000_000B) begin
            failures++;
            $display("[TB] FAIL bypass_on got=%h exp=%h", rdDataA[31:0], 32'h0000_000B);
        end
        checks++;
        if (rdDataB[31:0] !== 32'h0000_000A) begin
            failures++;
            $display("[TB] FAIL bypass_off_old got=%h exp=%h", rdDataB[31:0], 32'h0000_000A);
        end
        tick();
        wrEn = 1'b0;
        checks++;
        if (rdDataB[31:0] !== 32'h0000_000B) begin
            failures++;
            $display("[TB] FAIL bypass_off_new got=%h exp=%h", rdDataB[31:0], 32'h0000_000B);
        end
        checks++;
        if (rdDataC[31:0] !== 32'h0000_000B) begin
            failures++;
            $display("[TB] FAIL bypass_reg got=%h exp=%h", rdDataC[31:0], 32'h0000_000B);
        end
    endtask

    task automatic test_latency();
        doWrite(5'd9, 32'h0000_0055);
        doWrite(5'd10, 32'h0000_0066);
        applyStimulus(2'b00, 5'd0, 5'd0);
        tick();
        checks++;
        if (rdDataC[31:0] !== 32'h0) begin
            failures++;
            $display("[TB] FAIL lat_idle got=%h exp=%h", rdDataC[31:0], 32'h0);
        end
        applyStimulus(2'b01, 5'd0, 5'd9);
        #2;
        checks++;
        if (rdDataC[31:0] !== 32'h0) begin
            failures++;
            $display("[TB] FAIL lat_not_early got=%h exp=%h", rdDataC[31:0], 32'h0);
        end
        tick();
        checks++;
        if (rdDataC[31:0] !== 32'h0000_0055) begin
            failures++;
            $display("[TB] FAIL lat_x9 got=%h exp=%h", rdDataC[31:0], 32'h0000_0055);
        end
        applyStimulus(2'b01, 5'd0, 5'd10);
        #2;
        checks++;
        if (rdDataC[31:0] !== 32'h0000_0055) begin
            failures++;
            $display("[TB] FAIL lat_hold got=%h exp=%h", rdDataC[31:0], 32'h0000_0055);
        end
        tick();
        checks++;
        if (rdDataC[31:0] !== 32'h0000_0066) begin
            failures++;
            $display("[TB] FAIL lat_x10 got=%h exp=%h", rdDataC[31:0], 32'h0000_0066);
        end
        applyStimulus(2'b00, 5'd0, 5'd0);
        tick();
        checks++;
        if (rdDataC[31:0] !== 32'h0) begin
            failures++;
            $display("[TB] FAIL lat_one_cycle got=%h exp=%h", rdDataC[31:0], 32'h0);
        end
    endtask

    task automatic test_scoreboard();
        issueEn    = 1'b1;
        issueIndex = 5'd4;
        tick();
        issueEn = 1'b0;
        applyStimulus(2'b01, 5'd0, 5'd4);
        #1;
        checks++;
        if ({rdBusyA[0], rdBusyB[0]} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL sb_issue got=%b exp=%b", {rdBusyA[0], rdBusyB[0]}, 2'b11);
        end
        wrEn    = 1'b1;
        wrIndex = 5'd4;
        wrData  = 32'h0000_0044;
        #1;
        checks++;
        if ({rdBusyA[0], rdBusyB[0]} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL sb_wb_same_cycle got=%b exp=%b", {rdBusyA[0], rdBusyB[0]}, 2'b01);
        end
        tick();
        wrEn = 1'b0;
        #1;
        checks++;
        if ({rdBusyA[0], rdBusyB[0], rdBusyC[0]} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL sb_wb_after got=%b exp=%b", {rdBusyA[0], rdBusyB[0], rdBusyC[0]}, 3'b000);
        end
        issueEn    = 1'b1;
        issueIndex = 5'd4;
        wrEn       = 1'b1;
        wrIndex    = 5'd4;
        wrData     = 32'h0000_0045;
        tick();
        issueEn = 1'b0;
        wrEn    = 1'b0;
        #1;
        checks++;
        if ({rdBusyA[0], rdBusyB[0]} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL sb_set_wins got=%b exp=%b", {rdBusyA[0], rdBusyB[0]}, 2'b11);
        end
        checks++;
        if (rdDataA[31:0] !== 32'h0000_0045) begin
            failures++;
            $display("[TB] FAIL sb_set_wins_data got=%h exp=%h", rdDataA[31:0], 32'h0000_0045);
        end
        doWrite(5'd4, 32'h0000_0046);
        issueEn    = 1'b1;
        issueIndex = 5'd0;
        tick();
        issueEn = 1'b0;
        applyStimulus(2'b01, 5'd0, 5'd0);
        #1;
        checks++;
        if ({rdBusyA[0], rdBusyB[0]} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL sb_x0_never_busy got=%b exp=%b", {rdBusyA[0], rdBusyB[0]}, 2'b00);
        end
    endtask

    task automatic test_flush();
        issueEn    = 1'b1;
        issueIndex = 5'd1;
        tick();
        issueIndex = 5'd2;
        tick();
        issueIndex = 5'd31;
        tick();
        issueEn = 1'b0;
        applyStimulus(2'b11, 5'd2, 5'd1);
        #1;
        checks++;
        if (rdBusyA !== 2'b11) begin
            failures++;
            $display("[TB] FAIL flush_pre got=%b exp=%b", rdBusyA, 2'b11);
        end
        flush   = 1'b1;
        wrEn    = 1'b1;
        wrIndex = 5'd2;
        wrData  = 32'h0000_0077;
        tick();
        flush = 1'b0;
        wrEn  = 1'b0;
        #1;
        checks++;
        if ({rdBusyA, rdBusyB} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL flush_x1_x2 got=%b exp=%b", {rdBusyA, rdBusyB}, 4'b0000);
        end
        applyStimulus(2'b11, 5'd31, 5'd31);
        #1;
        checks++;
        if ({rdBusyA, rdBusyB} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL flush_x31 got=%b exp=%b", {rdBusyA, rdBusyB}, 4'b0000);
        end
        applyStimulus(2'b01, 5'd0, 5'd2);
        #1;
        checks++;
        if (rdDataA[31:0] !== 32'h0000_0077) begin
            failures++;
            $display("[TB] FAIL flush_write_data got=%h exp=%h", rdDataA[31:0], 32'h0000_0077);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_write_read();
        test_bypass();
        test_latency();
        test_scoreboard();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
